// File: rtl/coeff_interp_gen_pkg.sv
// Coefficient tables, coefficient type and legality check for the
// HEVC interpolation coefficient generator.
package coeff_interp_pkg;

    localparam int COEFF_W = 9;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    // Indexed [alpha][tap]; odd rows are illegal in luma mode and hold zeros.
    localparam int LUMA_COEFF [8][8] = '{
        '{ 0,  0,   0, 64,  0,   0,  0,  0},
        '{ 0,  0,   0,  0,  0,   0,  0,  0},
        '{-1,  4, -10, 58, 17,  -5,  1,  0},
        '{ 0,  0,   0,  0,  0,   0,  0,  0},
        '{-1,  4, -11, 40, 40, -11,  4, -1},
        '{ 0,  0,   0,  0,  0,   0,  0,  0},
        '{ 0,  1,  -5, 17, 58, -10,  4, -1},
        '{ 0,  0,   0,  0,  0,   0,  0,  0}
    };

    localparam int CHROMA_COEFF [8][4] = '{
        '{ 0, 64,  0,  0},
        '{-2, 58, 10, -2},
        '{-4, 54, 16, -2},
        '{-6, 46, 28, -4},
        '{-4, 36, 36, -4},
        '{-4, 28, 46, -6},
        '{-2, 16, 54, -4},
        '{-2, 10, 58, -2}
    };

    // Luma only defines even fractional positions; chroma defines all eight.
    function automatic logic coeff_legal(input logic [7:0] alpha, input logic chroma);
        if (alpha > 8'd7) return 1'b0;
        return chroma | ~alpha[0];
    endfunction

    function automatic coeff_t coeff_lookup(input logic [2:0] alpha, input logic [2:0] k,
                                            input logic chroma);
        if (chroma) return coeff_t'(CHROMA_COEFF[alpha][k[1:0]]);
        return coeff_t'(LUMA_COEFF[alpha][k]);
    endfunction

endpackage

// File: rtl/coeff_interp_gen_if.sv
// Multi-flux FIFO read and write interfaces. The actor modport is the
// side that consumes tokens / produces data; fifo is the FIFO side.
interface read_interface #(
    parameter int FLUX = 2,
    parameter int DW   = 4
) ();
    logic [FLUX-1:0] empty;
    logic [FLUX-1:0] read;
    logic [DW-1:0]   dout;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int FLUX = 2,
    parameter int DW   = 10
) ();
    logic [FLUX-1:0] full;
    logic            write;
    logic [DW-1:0]   din;

    modport actor (input full, output write, output din);
    modport fifo  (output full, input write, input din);
endinterface

// File: rtl/coeff_interp_gen_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer
// (wrapping), then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    logic [PW-1:0] ptr_q, ptr_d;

    // Scan requests from the pointer, modulo N, and compute the next pointer.
    always_comb begin
        logic          found;
        logic [PW:0]   idx;
        logic [PW-1:0] win;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
            if (!found && en && req[idx[PW-1:0]]) begin
                found             = 1'b1;
                gnt[idx[PW-1:0]]  = 1'b1;
                win               = idx[PW-1:0];
            end
        end
        if (found) ptr_d = (win == PW'(N-1)) ? '0 : win + PW'(1);
    end

    // Pointer register; restarts at requester 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/coeff_interp_gen.sv
// Coefficient generator: consumes tagged alpha tokens round-robin across
// fluxes and emits NTAP filter coefficients through a one-deep stage.
module coeff_interp_gen
    import coeff_interp_pkg::*;
#(
    parameter int FLUX        = 2,
    parameter int CHROMA      = 0,
    parameter int FRAC_WIDTH  = 3,
    parameter int COEFF_WIDTH = 9,
    localparam int NTAP       = (CHROMA == 0) ? 8 : 4,
    localparam int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    read_interface.actor         read_port_alpha,
    write_interface.actor        write_port_c [NTAP],
    output logic [7:0]           err_cnt,
    output logic [TAG_WIDTH-1:0] err_tag
);

    logic                          stage_valid_q, stage_valid_d;
    logic [TAG_WIDTH-1:0]          stage_tag_q, stage_tag_d;
    logic signed [COEFF_WIDTH-1:0] stage_coeff_q [NTAP];
    logic signed [COEFF_WIDTH-1:0] stage_coeff_d [NTAP];
    logic [7:0]                    err_cnt_q, err_cnt_d;
    logic [TAG_WIDTH-1:0]          err_tag_q, err_tag_d;

    logic [NTAP-1:0]       port_ready;
    logic                  drain;
    logic                  stage_free;
    logic [FLUX-1:0]       gnt;
    logic [TAG_WIDTH-1:0]  tok_tag;
    logic [FRAC_WIDTH-1:0] tok_alpha;
    logic                  tok_legal;

    assign tok_tag    = read_port_alpha.dout[TAG_WIDTH+FRAC_WIDTH-1 -: TAG_WIDTH];
    assign tok_alpha  = read_port_alpha.dout[FRAC_WIDTH-1:0];
    assign tok_legal  = coeff_legal(8'(tok_alpha), CHROMA != 0);

    // All ports write together or not at all.
    assign drain      = stage_valid_q & (&port_ready);
    assign stage_free = ~stage_valid_q | drain;

    for (genvar k = 0; k < NTAP; k++) begin : g_port
        assign port_ready[k]          = ~write_port_c[k].full[stage_tag_q];
        assign write_port_c[k].write  = drain;
        assign write_port_c[k].din    = {stage_tag_q, stage_coeff_q[k]};
    end

    // Reads are suppressed while reset is held so no token is lost.
    rr_arbiter #(.N(FLUX)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (~read_port_alpha.empty),
        .en  (stage_free & ~rst),
        .gnt (gnt)
    );

    assign read_port_alpha.read = gnt;
    assign err_cnt = err_cnt_q;
    assign err_tag = err_tag_q;

    // Stage load/drain and illegal-token bookkeeping.
    always_comb begin
        stage_valid_d = stage_valid_q & ~drain;
        stage_tag_d   = stage_tag_q;
        stage_coeff_d = stage_coeff_q;
        err_cnt_d     = err_cnt_q;
        err_tag_d     = err_tag_q;
        if (|gnt) begin
            if (tok_legal) begin
                stage_valid_d = 1'b1;
                stage_tag_d   = tok_tag;
                for (int k = 0; k < NTAP; k++)
                    stage_coeff_d[k] = COEFF_WIDTH'(coeff_lookup(tok_alpha[2:0], 3'(k), CHROMA != 0));
            end else begin
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                err_tag_d = tok_tag;
            end
        end
    end

    // Stage and error registers; reset discards any held stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_tag_q   <= '0;
            for (int k = 0; k < NTAP; k++) stage_coeff_q[k] <= '0;
            err_cnt_q     <= '0;
            err_tag_q     <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_tag_q   <= stage_tag_d;
            stage_coeff_q <= stage_coeff_d;
            err_cnt_q     <= err_cnt_d;
            err_tag_q     <= err_tag_d;
        end
    end

endmodule
